// File: rtl/fft_group_jump.sv
// fft_group_jump: butterfly half-group end detector for the radix-2 FFT
// address generator. Flags that prev_addr is the last element of a half-group
// at the given stage, so the generator skips the partner half.
// Optional build macro: GROUP_JUMP_COMB_EN -- when defined, jump/valid_out are
// purely combinational (zero latency) and clk/rst_n are unused.
// Default build registers both outputs with one cycle of latency.
module fft_group_jump #(
    parameter int ADDR_WIDTH = 13,
    parameter int STAGE_W    = $clog2(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [ADDR_WIDTH-1:0] prev_addr,
    input  logic [STAGE_W-1:0]    stage,
    output logic                  jump,
    output logic                  valid_out
);

    // jump_array[k] is set when the low k address bits are all ones.
    logic [ADDR_WIDTH-1:0] jump_array;
    logic                  jump_next;
    logic [31:0]           stage_ext;

    // Build the prefix-AND chain and select the entry for the current stage;
    // stages at or beyond ADDR_WIDTH never match and leave jump_next at 0.
    always_comb begin
        jump_array    = '0;
        jump_array[0] = 1'b1;
        for (int k = 1; k < ADDR_WIDTH; k++) begin
            jump_array[k] = jump_array[k-1] & prev_addr[k-1];
        end
        stage_ext = 32'(stage);
        jump_next = 1'b0;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            if (stage_ext == 32'(k)) begin
                jump_next = jump_array[k];
            end
        end
    end

`ifdef GROUP_JUMP_COMB_EN

    // Zero-latency path straight to the outputs.
    always_comb begin
        jump      = jump_next;
        valid_out = valid_in;
    end

`else

    logic jump_d;
    logic jump_q;
    logic valid_d;
    logic valid_q;

    // Next values: a new input is taken every cycle, no back-pressure.
    always_comb begin
        jump_d  = jump_next;
        valid_d = valid_in;
    end

    // Output registers; reset clears any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            jump_q  <= jump_d;
            valid_q <= valid_d;
        end
    end

    // Drive ports from the registers.
    always_comb begin
        jump      = jump_q;
        valid_out = valid_q;
    end

`endif

endmodule

// File: tb/tb_fft_group_jump.sv
// Bench for fft_group_jump: directed vectors, expected jump values pushed into
// a queue when issued, popped by a monitor whenever valid_out is high.
module tb_fft_group_jump;

    localparam int AW = 13;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [AW-1:0] prev_addr;
    logic [SW-1:0] stage;
    logic          jump;
    logic          valid_out;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;
    logic [0:0] exp_q[$];

    fft_group_jump #(.ADDR_WIDTH(AW), .STAGE_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .prev_addr (prev_addr),
        .stage     (stage),
        .jump      (jump),
        .valid_out (valid_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: present one valid input after the edge and record its expectation.
    task automatic send(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic e);
        @(posedge clk);
        #1;
        valid_in  = 1'b1;
        prev_addr = a;
        stage     = s;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Wait until all expected results have been consumed, bounded.
    task automatic drain(input string name);
        for (int i = 0; i < 8; i++) begin
            idle();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor / scoreboard: sample away from the active edge.
    always @(negedge clk) begin
        if (mon_en && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got valid_out=1 jump=%b, required no output", jump);
            end else begin
                chk("jump", jump, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic exp_rst;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        prev_addr = '0;
        stage     = 4'd13;
        #12;
        chk("reset_jump", jump, 1'b0);
        chk("reset_valid", valid_out, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // All-ones sweep: every legal stage jumps.
        for (int s = 0; s < AW; s++) send(13'h1FFF, SW'(s), 1'b1);
        // Zero address: only stage 0.
        for (int s = 0; s < AW; s++) send(13'h0000, SW'(s), (s == 0) ? 1'b1 : 1'b0);
        // Low three bits set: stages 0..3 jump.
        for (int s = 0; s < AW; s++) send(13'h0007, SW'(s), (s <= 3) ? 1'b1 : 1'b0);
        // Same with MSB set: MSB ignored.
        for (int s = 0; s < AW; s++) send(13'h1007, SW'(s), (s <= 3) ? 1'b1 : 1'b0);
        // Illegal stages never jump.
        send(13'h1FFF, 4'd13, 1'b0);
        send(13'h1FFF, 4'd14, 1'b0);
        send(13'h1FFF, 4'd15, 1'b0);
        // Mixed single patterns.
        send(13'h0FFF, 4'd12, 1'b1);
        send(13'h0FFE, 4'd12, 1'b0);
        send(13'h0FFE, 4'd0,  1'b1);
        send(13'h0FFE, 4'd1,  1'b0);
        drain("drain_sweeps");

        // Reset pulse between edges.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        valid_in  = 1'b1;
        prev_addr = 13'h1FFF;
        stage     = 4'd5;
        @(posedge clk);
        #1;
        chk("pre_reset_jump", jump, 1'b1);
        chk("pre_reset_valid", valid_out, 1'b1);
`ifdef GROUP_JUMP_COMB_EN
        exp_rst = 1'b1;
`else
        exp_rst = 1'b0;
`endif
        #1;
        rst_n = 1'b0;
        #1;
        chk("in_reset_jump", jump, exp_rst);
        chk("in_reset_valid", valid_out, exp_rst);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_release_jump", jump, exp_rst);
        chk("post_release_valid", valid_out, exp_rst);
        @(posedge clk);
        #1;
        chk("after_edge_jump", jump, 1'b1);
        chk("after_edge_valid", valid_out, 1'b1);
        idle();
        idle();
        chk("idle_valid", valid_out, 1'b0);
        mon_en = 1'b1;

        // Back-to-back toggling, with one idle bubble.
        send(13'h000F, 4'd4, 1'b1);
        send(13'h000E, 4'd4, 1'b0);
        send(13'h000F, 4'd4, 1'b1);
        send(13'h000E, 4'd4, 1'b0);
        idle();
        send(13'h000F, 4'd4, 1'b1);
        send(13'h000E, 4'd4, 1'b0);
        drain("drain_b2b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_group_jump.md
# fft_group_jump

Group-boundary detector for the shared-butterfly radix-2 FFT address generator. Given the previously issued data address and the current FFT stage, it flags that the address sits at the last element of a butterfly half-group. The address generator must then skip the partner half instead of incrementing by one. It sits between the address counter and the next-address adder. The result is registered by default, with an optional combinational path.

## Interface
Parameters:
- `ADDR_WIDTH`, default 13: data address width (N = 2^ADDR_WIDTH points); also the number of stages.
- `STAGE_W`, default `$clog2(ADDR_WIDTH)` (4): width of `stage`.

Ports:
- `clk`  input  1  single clock; all state is on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `valid_in`  input  1  `prev_addr`/`stage` are meaningful this cycle.
- `prev_addr`  input  ADDR_WIDTH  previously issued address.
- `stage`  input  STAGE_W  current stage, 0..ADDR_WIDTH-1.
- `jump`  output  1  group-end flag.
- `valid_out`  output  1  `jump` qualifies a valid input.

## Operation
- Internal `jump_array[ADDR_WIDTH-1:0]`:
  - `jump_array[0]` = 1.
  - `jump_array[k]` = AND of `prev_addr[k-1:0]` for k ≥ 1, i.e. the low k bits are all ones.
- `jump_next` = `jump_array[stage]` when `stage` < ADDR_WIDTH.
- `jump_next` = 0 when `stage` ≥ ADDR_WIDTH (values 13..15 at the default).
- Only `prev_addr[ADDR_WIDTH-2:0]` affects the result; the MSB is ignored.
- If `prev_addr` is all ones, `jump_next` = 1 for every legal stage.
- If `prev_addr` = 0, `jump_next` = 1 only at stage 0.
- `jump_next` is computed regardless of `valid_in`. `valid_out` mirrors `valid_in` with the same latency as `jump`.
- No state machine. The only storage is the output registers.

## Timing
- Default (registered) mode:
  - `jump` <= `jump_next` and `valid_out` <= `valid_in` on each rising edge of `clk`.
  - Latency is 1 cycle. A new input is accepted every cycle, with no back-pressure.
- `rst_n` low, asynchronous, forces `jump` = 0 and `valid_out` = 0 immediately.
- The first capture is on the first rising edge after `rst_n` deasserts.
- Reset asserted mid-stream drops the in-flight result. It is not replayed.
- `stage` and `prev_addr` may change every cycle; no ordering requirements apply.
- Combinational mode: see Configuration.

## Configuration
- Macro `GROUP_JUMP_COMB_EN`.
- Defined:
  - `jump` = `jump_next` and `valid_out` = `valid_in`, purely combinational, zero latency.
  - `clk` and `rst_n` are unused, but the ports remain.
- Not defined: registered 1-cycle behaviour as described under Timing.

## Test plan
- All-ones sweep: `prev_addr` = 0x1FFF, `stage` = 0..12, `valid_in` = 1 → `jump` = 1 for every stage, one cycle after each input (combinational mode: immediately).
- Zero address: `prev_addr` = 0x0000, `stage` = 0..12 → `jump` = 1 only at stage 0, 0 otherwise.
- Boundary pattern: `prev_addr` = 0x0007 → `jump` = 1 for stages 0..3 and 0 for stages 4..12. With `prev_addr` = 0x1007, the result is identical, showing the MSB is ignored.
- Illegal stage: `prev_addr` = 0x1FFF, `stage` = 13, 14, 15 → `jump` = 0.
- Reset: drive `prev_addr` = 0x1FFF, `stage` = 5, `valid_in` = 1, then pulse `rst_n` low between edges → `jump` and `valid_out` fall to 0 at once. Both return to 1 on the first edge after release.
- Back-to-back: alternate `prev_addr` 0x000F and 0x000E at `stage` = 4 every cycle → `jump` toggles 1, 0, 1, 0 one cycle delayed, and `valid_out` tracks `valid_in`.
